trap_sequencer: RTL

Multi-cycle controller that owns the single write port of the machine-mode CSR file (CSRRegs) and sequences trap entry and MRET return. It arbitrates that port between Zicsr instructions from MEM and its own trap-save writes, prioritises simultaneous exception causes, and generates pipeline flush, stall and PC-redirect controls. It sits beside the exception unit, between the MEM/WB stage signals and CSRRegs.

---
 rtl/trap_pkg.sv | 50 +++++
 rtl/trap_prio_enc.sv | 38 +++
 rtl/trap_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - CSR addresses, trap cause codes, mstatus bit positions and sequencer states.
package trap_pkg;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MTVAL   = 12'h343;

   localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
   localparam logic [31:0] CAUSE_ECALL_M   = 32'd11;
   localparam logic [31:0] CAUSE_S_FAULT   = 32'd7;
   localparam logic [31:0] CAUSE_L_FAULT   = 32'd5;
   localparam logic [31:0] CAUSE_M_EXT_INT = 32'h8000_000B;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [1:0] WSC_WRITE = 2'b01;

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_W_EPC    = 4'd1;
   localparam logic [3:0] S_W_CAUSE  = 4'd2;
   localparam logic [3:0] S_W_TVAL   = 4'd3;
   localparam logic [3:0] S_W_STATUS = 4'd4;
   localparam logic [3:0] S_RD_VEC   = 4'd5;
   localparam logic [3:0] S_REDIR    = 4'd6;
   localparam logic [3:0] S_R_STATUS = 4'd7;
   localparam logic [3:0] S_RD_EPC   = 4'd8;

   function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
      logic [31:0] r;
      r = ms;
      r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
      r[MSTATUS_MIE] = 1'b0;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return r;
   endfunction

   function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
      logic [31:0] r;
      r = ms;
      r[MSTATUS_MIE] = ms[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - picks the highest-priority trap cause of the WB instruction.
module trap_prio_enc
   import trap_pkg::*;
(
   input  logic        illegal_inst,
   input  logic        ecall_m,
   input  logic        s_access_fault,
   input  logic        l_access_fault,
   input  logic        interrupt,
   input  logic        mie,
   input  logic        mret,
   output logic        take_trap,
   output logic        is_intr,
   output logic [31:0] cause
);

   always_comb begin
      take_trap = 1'b1;
      is_intr   = 1'b0;
      cause     = '0;
      if (illegal_inst) begin
         cause = CAUSE_ILLEGAL;
      end else if (ecall_m) begin
         cause = CAUSE_ECALL_M;
      end else if (s_access_fault) begin
         cause = CAUSE_S_FAULT;
      end else if (l_access_fault) begin
         cause = CAUSE_L_FAULT;
      end else if (interrupt && mie && !mret) begin
         // an MRET in WB outranks a pending interrupt; it is re-sampled afterwards
         is_intr = 1'b1;
         cause   = CAUSE_M_EXT_INT;
      end else begin
         take_trap = 1'b0;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - owns the CSR write port; sequences trap entry and MRET return.
// Optional TRAP_VECTORED_EN: vectored mtvec mode for interrupts.
module trap_sequencer
   import trap_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        interrupt,
   input  logic        illegal_inst,
   input  logic        ecall_m,
   input  logic        s_access_fault,
   input  logic        l_access_fault,
   input  logic        mret,
   input  logic [31:0] epc_cur,
   input  logic [31:0] epc_next,
   input  logic [31:0] tval_in,
   input  logic [31:0] mstatus,
   input  logic [31:0] csr_rdata,
   input  logic        csr_req,
   input  logic [11:0] csr_req_addr,
   input  logic [31:0] csr_req_wdata,
   input  logic [1:0]  csr_req_wsc,
   output logic        csr_gnt,
   output logic        csr_w,
   output logic [11:0] csr_waddr,
   output logic [11:0] csr_raddr,
   output logic [31:0] csr_wdata,
   output logic [1:0]  csr_wsc,
   output logic [31:0] PC_redirect,
   output logic        redirect_mux,
   output logic        reg_FD_flush,
   output logic        reg_DE_flush,
   output logic        reg_EM_flush,
   output logic        reg_MW_flush,
   output logic        RegWrite_cancel,
   output logic        stall_pipe
);

   logic [3:0]  state_q, state_d;
   logic [31:0] epc_q, epc_d, cause_q, cause_d, tval_q, tval_d, target_q, target_d;
   logic [31:0] cause, vec_base;
   logic        take_trap, is_intr, idle, do_trap, do_mret;

   trap_prio_enc u_prio (
      .illegal_inst   (illegal_inst),
      .ecall_m        (ecall_m),
      .s_access_fault (s_access_fault),
      .l_access_fault (l_access_fault),
      .interrupt      (interrupt),
      .mie            (mstatus[MSTATUS_MIE]),
      .mret           (mret),
      .take_trap      (take_trap),
      .is_intr        (is_intr),
      .cause          (cause)
   );

   // gating with rst keeps every output low while reset is held
   assign idle     = rst && (state_q == S_IDLE);
   assign do_trap  = idle && take_trap;
   assign do_mret  = idle && mret && !take_trap;
   assign vec_base = {csr_rdata[31:2], 2'b00};

   always_comb begin
      state_d         = state_q;
      epc_d           = epc_q;
      cause_d         = cause_q;
      tval_d          = tval_q;
      target_d        = target_q;
      csr_gnt         = 1'b0;
      csr_w           = 1'b0;
      csr_waddr       = '0;
      csr_raddr       = '0;
      csr_wdata       = '0;
      csr_wsc         = '0;
      PC_redirect     = '0;
      redirect_mux    = 1'b0;
      reg_FD_flush    = 1'b0;
      reg_DE_flush    = 1'b0;
      reg_EM_flush    = 1'b0;
      reg_MW_flush    = 1'b0;
      RegWrite_cancel = 1'b0;
      stall_pipe      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (do_trap || do_mret) begin
               reg_FD_flush = 1'b1;
               reg_DE_flush = 1'b1;
               reg_EM_flush = 1'b1;
               reg_MW_flush = 1'b1;
               stall_pipe   = 1'b1;
            end
            if (do_trap) begin
               RegWrite_cancel = 1'b1;
               epc_d   = is_intr ? epc_next : epc_cur;
               cause_d = cause;
               tval_d  = (is_intr || cause == CAUSE_ECALL_M) ? '0 : tval_in;
               state_d = S_W_EPC;
            end else if (do_mret) begin
               state_d = S_R_STATUS;
            end else if (idle && csr_req) begin
               csr_gnt   = 1'b1;
               csr_w     = 1'b1;
               csr_waddr = csr_req_addr;
               csr_raddr = csr_req_addr;
               csr_wdata = csr_req_wdata;
               csr_wsc   = csr_req_wsc;
            end
         end
         S_W_EPC, S_W_CAUSE, S_W_TVAL, S_W_STATUS, S_R_STATUS: begin
            stall_pipe = 1'b1;
            csr_w      = 1'b1;
            csr_wsc    = WSC_WRITE;
            case (state_q)
               S_W_EPC: begin
                  csr_waddr = ADDR_MEPC;
                  csr_wdata = epc_q;
                  state_d   = S_W_CAUSE;
               end
               S_W_CAUSE: begin
                  csr_waddr = ADDR_MCAUSE;
                  csr_wdata = cause_q;
                  state_d   = S_W_TVAL;
               end
               S_W_TVAL: begin
                  csr_waddr = ADDR_MTVAL;
                  csr_wdata = tval_q;
                  state_d   = S_W_STATUS;
               end
               S_W_STATUS: begin
                  csr_waddr = ADDR_MSTATUS;
                  csr_wdata = mstatus_on_trap(mstatus);
                  state_d   = S_RD_VEC;
               end
               default: begin
                  csr_waddr = ADDR_MSTATUS;
                  csr_wdata = mstatus_on_mret(mstatus);
                  state_d   = S_RD_EPC;
               end
            endcase
         end
         S_RD_VEC: begin
            stall_pipe = 1'b1;
            csr_raddr  = ADDR_MTVEC;
            target_d   = vec_base;
`ifdef TRAP_VECTORED_EN
            if (csr_rdata[1:0] == 2'b01 && cause_q[31])
               target_d = vec_base + {cause_q[29:0], 2'b00};
`endif
            state_d = S_REDIR;
         end
         S_RD_EPC: begin
            stall_pipe = 1'b1;
            csr_raddr  = ADDR_MEPC;
            target_d   = csr_rdata;
            state_d    = S_REDIR;
         end
         S_REDIR: begin
            stall_pipe   = 1'b1;
            redirect_mux = 1'b1;
            PC_redirect  = target_q;
            reg_FD_flush = 1'b1;
            reg_DE_flush = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         epc_q    <= '0;
         cause_q  <= '0;
         tval_q   <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         epc_q    <= epc_d;
         cause_q  <= cause_d;
         tval_q   <= tval_d;
         target_q <= target_d;
      end
   end

endmodule
